// File: rtl/uart_tx.sv
// Purpose: 8N1 serial transmitter with a small transmit FIFO and CPU status bits (tbre/tsre/overflow).
// Latency: a byte written at edge E is popped at E+1, and tx falls at E+1; each frame is 10*CLK_DIV cycles.
// Backpressure: tbre drops when the FIFO is full; a write while full is dropped unless a pop happens in the same cycle.

module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [DW-1:0]    push_dat,
    input  logic             pop_vld,
    output logic [DW-1:0]    head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    // Purpose: synchronous circular-buffer FIFO, head visible combinationally.
    // Latency: a push at edge E is visible at the head after E.
    // Backpressure: a push is accepted when not full, or when a pop happens in the same cycle.

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop_vld && !empty;
    assign do_push  = push_vld && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

module uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             tx,
    output logic             tbre,
    output logic             tsre,
    output logic             overflow,
    output logic [CNT_W-1:0] fifo_count
);
    // Purpose: shifts queued bytes out as 8N1 frames, LSB first, on an idle-high line.
    // Latency: tx falls one edge after the write edge; back-to-back frames are contiguous.
    // Backpressure: tbre=0 while full; a dropped write sets the sticky overflow flag.

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n;
    logic          ovf_q;
    logic          pop;
    logic          baud_done;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    head;

    sync_fifo #(
        .DW    (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (wr_en),
        .push_dat (wr_data),
        .pop_vld  (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign baud_done = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_done ? '0 : baud_cnt + 1'b1;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = tx_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_n       = 1'b1;
                baud_cnt_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    tx_n      = shift[0];
                    shift_n   = {1'b0, shift[7:1]};
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift[0];
                        shift_n   = {1'b0, shift[7:1]};
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued frames leave no idle gap.
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx_q     <= tx_n;
            if (wr_en && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign tx       = tx_q;
    assign overflow = ovf_q;
    assign tbre     = !fifo_full;
    assign tsre     = (state == IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized and directed stimulus for uart_tx, checked every cycle against a queue-based frame model.

module tb_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             tx;
    logic             tbre;
    logic             tsre;
    logic             overflow;
    logic [CNT_W-1:0] fifo_count;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: byte queue, plus a queue of future per-cycle line levels.
    logic [7:0] mq[$];
    bit         ms[$];
    bit         m_tx   = 1'b1;
    bit         m_busy = 1'b0;
    bit         m_ovf  = 1'b0;

    uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tx         (tx),
        .tbre       (tbre),
        .tsre       (tsre),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit we, input logic [7:0] d);
        logic [9:0] fr;
        bit         popped;
        if (!r) begin
            mq.delete();
            ms.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            popped = (ms.size() == 0) && (mq.size() > 0);
            if (popped) begin
                fr = {1'b1, mq.pop_front(), 1'b0};
                for (int k = 0; k < 10; k++) begin
                    repeat (CLK_DIV) ms.push_back(fr[k]);
                end
            end
            if (we) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else m_ovf = 1'b1;
            end
            if (ms.size() > 0) begin
                m_tx   = ms.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, input bit we, input logic [7:0] d);
        rst     = r;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        model_edge(r, we, d);
        #1;
        check_eq("tx", 32'(tx), 32'(m_tx));
        check_eq("tsre", 32'(tsre), 32'(!m_busy && mq.size() == 0));
        check_eq("tbre", 32'(tbre), 32'(mq.size() != DEPTH));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        bit found;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        // Reset on the first edge, then a long idle stretch.
        step(1'b0, 1'b0, 8'h00);
        check_eq("reset_tx", 32'(tx), 32'd1);
        check_eq("reset_count", 32'(fifo_count), 32'd0);
        idle(100);

        // Single byte 0x55.
        step(1'b1, 1'b1, 8'h55);
        check_eq("w55_tsre_low", 32'(tsre), 32'd0);
        idle(45);

        // Two contiguous frames.
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'hFF);
        idle(85);

        // Overflow: 0x06 dropped.
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1, 8'(i));
            if (i == 5) check_eq("ovf_tbre_after5", 32'(tbre), 32'd0);
        end
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        idle(210);

        // Full FIFO, write coincides with the pop at the end of a stop bit.
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h10 + i));
        check_eq("full_count", 32'(fifo_count), 32'd4);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (ms.size() == 0 && m_busy) found = 1'b1;
            else step(1'b1, 1'b0, 8'h00);
        end
        check_eq("a5_wait_found", 32'(found), 32'd1);
        step(1'b1, 1'b1, 8'hA5);
        check_eq("a5_count", 32'(fifo_count), 32'd4);
        check_eq("a5_no_ovf", 32'(overflow), 32'd0);
        idle(250);

        // Reset during data bit 3 with two bytes queued and a write on the reset edge.
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h3C);
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b1, 8'h22);
        idle(15);
        check_eq("midreset_queued", 32'(fifo_count), 32'd2);
        step(1'b0, 1'b1, 8'h77);
        check_eq("midreset_tx", 32'(tx), 32'd1);
        check_eq("midreset_count", 32'(fifo_count), 32'd0);
        check_eq("midreset_tsre", 32'(tsre), 32'd1);
        check_eq("midreset_tbre", 32'(tbre), 32'd1);
        check_eq("midreset_ovf", 32'(overflow), 32'd0);
        idle(60);

        // Random traffic with rare resets, then drain.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 99) < 30), 8'($urandom));
        end
        idle(250);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
